// File: rtl/masked_and_arbiter.sv
// masked_and_arbiter: round-robin front end for one shared pipelined masked AND gadget.
// An operation issues only when fresh randomness is present. A tag pipeline as deep as
// the gadget latency routes each result back to the requester that issued it. All gadget
// operand buses are zero whenever nothing issues, so shares of different operations are
// never combined.
//
// Handshake: requester i hands over an operation on a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is one-hot and goes high only on an issue cycle.
// rnd_ready is high exactly when rnd_in is consumed. Responses have no backpressure:
// resp_valid[i] is high for one cycle only.
module masked_and_arbiter #(
    parameter int N   = 4,
    parameter int D   = 2,
    parameter int W   = 8,
    parameter int LAT = 2,
    parameter int R   = 8
) (
    input  logic             clk,
    input  logic             syn_rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*D*W-1:0] req_ina,
    input  logic [N*D*W-1:0] req_inb,
    input  logic             rnd_valid,
    input  logic [R-1:0]     rnd_in,
    output logic             rnd_ready,
    output logic [D*W-1:0]   g_ina,
    output logic [D*W-1:0]   g_inb,
    output logic [R-1:0]     g_rnd,
    input  logic [D*W-1:0]   g_out,
    output logic [N-1:0]     resp_valid,
    output logic [D*W-1:0]   resp_data,
    output logic             busy
);

    localparam int DW = D * W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic          found;
    logic          issue;
    logic [IW-1:0] cand;
    int            j;

    logic [LAT-1:0] tag_v;
    logic [IW-1:0]  tag_idx [LAT];

    // Round-robin search: take the first valid requester, starting at ptr and wrapping.
    always_comb begin
        grant_idx = ptr;
        found     = 1'b0;
        cand      = '0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            cand = IW'(j);
            if (!found && req_valid[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
    end

    // Issue needs both a pending request and fresh randomness. Nothing issues during reset.
    assign issue     = rnd_valid & (|req_valid) & ~syn_rst;
    assign rnd_ready = issue;

    // One-hot grant, plus an AND-with-grant / OR mux. Unselected shares are masked
    // before they are combined, so they never reach the gadget.
    always_comb begin
        req_ready = '0;
        g_ina     = '0;
        g_inb     = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = issue && (grant_idx == IW'(i));
            g_ina = g_ina | (req_ina[i*DW +: DW] & {DW{req_ready[i]}});
            g_inb = g_inb | (req_inb[i*DW +: DW] & {DW{req_ready[i]}});
        end
        g_rnd = rnd_in & {R{issue}};
    end

    // Round-robin pointer: after an issue, it moves to the slot just past the granted requester.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // Tag pipeline: a valid bit and a requester index travel alongside the gadget's own latency.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            tag_v <= '0;
            for (int k = 0; k < LAT; k++) tag_idx[k] <= '0;
        end else begin
            tag_v[0]   <= issue;
            tag_idx[0] <= grant_idx;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]   <= tag_v[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    // Route the gadget result to its owner. The data bus is zero when no tag is due.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N; i++) begin
            resp_valid[i] = tag_v[LAT-1] && (tag_idx[LAT-1] == IW'(i));
        end
        resp_data = g_out & {DW{tag_v[LAT-1]}};
        busy      = |tag_v;
    end

endmodule
